// File: rtl/debounce_pkg.sv
// debounce_pkg: shared constants and helpers for the multi-channel debouncer.
// Optional feature macro used by the design files: DEBOUNCE_EDGE_EN
// (enables the registered rise/fall pulse outputs).
package debounce_pkg;

    // Number of flops in each channel's input synchroniser.
    localparam int SYNC_STAGES = 2;

    // Width of the per-channel stability counter: max(1, clog2(stable_cycles)).
    function automatic int cnt_width(input int stable_cycles);
        int w;
        w = $clog2(stable_cycles);
        return (w < 1) ? 1 : w;
    endfunction

    // True when the block parameters describe a buildable debouncer.
    function automatic bit params_ok(input int channels, input int stable_cycles);
        return (channels >= 1) && (stable_cycles >= 1);
    endfunction

endpackage : debounce_pkg

// File: rtl/debounce_chan.sv
// debounce_chan: one debounce channel -- 2-flop synchroniser, stability
// counter, registered debounced level and (with DEBOUNCE_EDGE_EN defined)
// one-cycle rise/fall pulses. Without DEBOUNCE_EDGE_EN the pulse ports are
// tied low and no edge registers exist.
module debounce_chan #(
    parameter int   STABLE_CYCLES = 8,
    parameter logic RESET_VAL     = 1'b0
) (
    input  logic clock,
    input  logic reset_n,
    input  logic sample_en,
    input  logic in,
    output logic out,
    output logic rise,
    output logic fall
);
    import debounce_pkg::*;

    localparam int            CW       = cnt_width(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_out;
    logic [CW-1:0]          r_cnt;

    logic w_s2;
    logic w_match;
    logic w_accept;

    assign w_s2     = r_sync[SYNC_STAGES-1];
    // An agreeing sample always wins, so abort beats accept on the boundary cycle.
    assign w_match  = (w_s2 == r_out);
    assign w_accept = !w_match && sample_en && (r_cnt == CNT_LAST);

    // Synchronise the raw pin, then qualify any change with the stability counter.
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values of its neighbours, which is what makes the
    // synchroniser a real two-stage shift.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sync <= {SYNC_STAGES{RESET_VAL}};
            r_out  <= RESET_VAL;
            r_cnt  <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], in};
            if (w_match) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                r_out <= w_s2;
                r_cnt <= '0;
            end else if (sample_en) begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign out = r_out;

`ifdef DEBOUNCE_EDGE_EN
    logic r_rise;
    logic r_fall;

    // Pulse for exactly the cycle in which the debounced level changes.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_rise <= w_accept &  w_s2;
            r_fall <= w_accept & ~w_s2;
        end
    end

    assign rise = r_rise;
    assign fall = r_fall;
`else
    assign rise = 1'b0;
    assign fall = 1'b0;
`endif

endmodule : debounce_chan

// File: rtl/debounce_multi.sv
// debounce_multi: CHANNELS independent debounce channels sharing only the
// clock, reset and sample-enable tick. Define DEBOUNCE_EDGE_EN to generate
// the rise/fall pulse outputs; otherwise they are constant 0.
module debounce_multi #(
    parameter int   CHANNELS      = 4,
    parameter int   STABLE_CYCLES = 8,
    parameter logic RESET_VAL     = 1'b0
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                sample_en,
    input  logic [CHANNELS-1:0] IN,
    output logic [CHANNELS-1:0] OUT,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall
);
    import debounce_pkg::*;

    // Refuse to elaborate with a zero channel count or zero stability window.
    if (!params_ok(CHANNELS, STABLE_CYCLES)) begin : g_param_err
        $error("debounce_multi: CHANNELS and STABLE_CYCLES must both be >= 1");
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        debounce_chan #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .RESET_VAL     (RESET_VAL)
        ) u_chan (
            .clock     (clock),
            .reset_n   (reset_n),
            .sample_en (sample_en),
            .in        (IN[i]),
            .out       (OUT[i]),
            .rise      (rise[i]),
            .fall      (fall[i])
        );
    end

endmodule : debounce_multi

// File: tb/tb_debounce_multi.sv
// tb_debounce_multi: self-checking bench for debounce_multi at its default
// parameters (4 channels, 8 stable cycles, reset level 0). Expected pulse
// values are masked to zero unless DEBOUNCE_EDGE_EN is defined.
module tb_debounce_multi;

`ifdef DEBOUNCE_EDGE_EN
    localparam logic [3:0] EDGE_MASK = 4'hF;
`else
    localparam logic [3:0] EDGE_MASK = 4'h0;
`endif

    logic       clock     = 1'b0;
    logic       reset_n   = 1'b1;
    logic       sample_en = 1'b0;
    logic [3:0] in_r      = 4'h0;
    logic [3:0] out_w;
    logic [3:0] rise_w;
    logic [3:0] fall_w;

    always #5 clock = ~clock;

    debounce_multi #(
        .CHANNELS      (4),
        .STABLE_CYCLES (8),
        .RESET_VAL     (1'b0)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .sample_en (sample_en),
        .IN        (in_r),
        .OUT       (out_w),
        .rise      (rise_w),
        .fall      (fall_w)
    );

    typedef struct {
        string      name;
        logic [3:0] out;
        logic [3:0] rise;
        logic [3:0] fall;
    } exp_t;

    typedef struct {
        string      name;
        logic       rst_n;
        logic       se;
        logic [3:0] in;
        int         hold;
        logic [3:0] out;
        logic [3:0] rise;
        logic [3:0] fall;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Drive one clock's worth of inputs, queue the expectation, clock once,
    // then compare what the DUT produced against the oldest expectation.
    task automatic cycle(input string name, input logic rst, input logic se,
                         input logic [3:0] vin, input logic [3:0] eout,
                         input logic [3:0] erise, input logic [3:0] efall);
        exp_t e;
        exp_t got;
        reset_n   = rst;
        sample_en = se;
        in_r      = vin;
        e.name = name;
        e.out  = eout;
        e.rise = erise & EDGE_MASK;
        e.fall = efall & EDGE_MASK;
        sb_q.push_back(e);
        @(posedge clock);
        @(negedge clock);
        got = sb_q.pop_front();
        check({got.name, " OUT"},  out_w,  got.out);
        check({got.name, " rise"}, rise_w, got.rise);
        check({got.name, " fall"}, fall_w, got.fall);
    endtask

    task automatic add(input string name, input logic rst, input logic se,
                       input logic [3:0] vin, input int hold, input logic [3:0] eout,
                       input logic [3:0] erise, input logic [3:0] efall);
        vec_t v;
        v.name = name; v.rst_n = rst; v.se = se; v.in = vin; v.hold = hold;
        v.out = eout; v.rise = erise; v.fall = efall;
        vecs.push_back(v);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] v_in;
        #1 reset_n = 1'b0;
        @(negedge clock);

        //  name            rst se  IN  hold OUT rise fall
        add("rst_hold",      0, 1, 4'hF, 3, 4'h0, 4'h0, 4'h0);
        add("rise_wait",     1, 1, 4'hF, 9, 4'h0, 4'h0, 4'h0);
        add("rise_acc",      1, 1, 4'hF, 1, 4'hF, 4'hF, 4'h0);
        add("rise_after",    1, 1, 4'hF, 4, 4'hF, 4'h0, 4'h0);
        add("fall_wait",     1, 1, 4'h0, 9, 4'hF, 4'h0, 4'h0);
        add("fall_acc",      1, 1, 4'h0, 1, 4'h0, 4'h0, 4'hF);
        add("fall_after",    1, 1, 4'h0, 3, 4'h0, 4'h0, 4'h0);
        add("glitch7_hi",    1, 1, 4'h1, 7, 4'h0, 4'h0, 4'h0);
        add("glitch7_lo",    1, 1, 4'h0, 6, 4'h0, 4'h0, 4'h0);
        add("glitch8_hi",    1, 1, 4'h1, 8, 4'h0, 4'h0, 4'h0);
        add("glitch8_lo",    1, 1, 4'h0, 1, 4'h0, 4'h0, 4'h0);
        add("glitch8_acc",   1, 1, 4'h0, 1, 4'h1, 4'h1, 4'h0);
        add("glitch8_back",  1, 1, 4'h0, 7, 4'h1, 4'h0, 4'h0);
        add("glitch8_fall",  1, 1, 4'h0, 1, 4'h0, 4'h0, 4'h1);
        add("glitch8_idle",  1, 1, 4'h0, 2, 4'h0, 4'h0, 4'h0);
        add("se_low_hold",   1, 0, 4'h8, 20, 4'h0, 4'h0, 4'h0);
        add("se_high_cnt",   1, 1, 4'h8, 7, 4'h0, 4'h0, 4'h0);
        add("se_high_acc",   1, 1, 4'h8, 1, 4'h8, 4'h8, 4'h0);
        add("se_idle",       1, 1, 4'h8, 2, 4'h8, 4'h0, 4'h0);
        add("abort_hi",      1, 1, 4'hC, 7, 4'h8, 4'h0, 4'h0);
        add("abort_lo",      1, 1, 4'h8, 6, 4'h8, 4'h0, 4'h0);
        add("recount_hi",    1, 1, 4'hC, 9, 4'h8, 4'h0, 4'h0);
        add("recount_acc",   1, 1, 4'hC, 1, 4'hC, 4'h4, 4'h0);
        add("recount_back",  1, 1, 4'h8, 9, 4'hC, 4'h0, 4'h0);
        add("recount_fall",  1, 1, 4'h8, 1, 4'h8, 4'h0, 4'h4);
        add("recount_idle",  1, 1, 4'h8, 2, 4'h8, 4'h0, 4'h0);

        foreach (vecs[n]) begin
            for (int c = 0; c < vecs[n].hold; c++) begin
                cycle(vecs[n].name, vecs[n].rst_n, vecs[n].se, vecs[n].in,
                      vecs[n].out, vecs[n].rise, vecs[n].fall);
            end
        end

        // Prescaled sampling: tick on edges 3, 7, 11, ... so the 8th enabled
        // edge after the synchroniser settles is edge 31.
        for (int k = 1; k <= 34; k++) begin
            cycle("prescale", 1'b1, ((k % 4) == 3), 4'hA,
                  (k >= 31) ? 4'hA : 4'h8,
                  (k == 31) ? 4'h2 : 4'h0, 4'h0);
        end

        // Channel 0 pending while channel 3 chatters in bursts shorter than
        // the window: channel 0 accepts on schedule, channel 3 never moves.
        for (int k = 1; k <= 12; k++) begin
            v_in = ((k % 6) >= 3) ? 4'hB : 4'h3;
            cycle("indep", 1'b1, 1'b1, v_in,
                  (k >= 10) ? 4'hB : 4'hA,
                  (k == 10) ? 4'h1 : 4'h0, 4'h0);
        end

        // Channel 0 now counting toward a fall; reset lands mid-count.
        for (int k = 1; k <= 5; k++) begin
            cycle("pre_reset", 1'b1, 1'b1, 4'hA, 4'hB, 4'h0, 4'h0);
        end
        reset_n = 1'b0;
        #1;
        check("async_reset OUT",  out_w,  4'h0);
        check("async_reset rise", rise_w, 4'h0);
        check("async_reset fall", fall_w, 4'h0);
        @(negedge clock);
        for (int k = 1; k <= 2; k++) begin
            cycle("reset_hold", 1'b0, 1'b1, 4'hA, 4'h0, 4'h0, 4'h0);
        end
        for (int k = 1; k <= 12; k++) begin
            cycle("post_reset", 1'b1, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_debounce_multi
